// File: rtl/lz77_decoder_stream.sv
// lz77_decoder_stream: expands (pos, len, literal) tokens into one character per cycle
// using a shift-register search buffer, with valid/ready back-pressure on both sides.
module lz77_decoder_stream #(
   parameter int SEARCH_DEPTH = 9,
   parameter int CHAR_W = 8,
   parameter int POS_W = 4,
   parameter int LEN_W = 3,
   parameter logic [CHAR_W-1:0] END_CHAR = CHAR_W'('h24)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [POS_W-1:0]  code_pos,
   input  logic [LEN_W-1:0]  code_len,
   input  logic [CHAR_W-1:0] chardata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CHAR_W-1:0] char_nxt,
   output logic              finish,
   output logic              pos_err
);
   typedef enum logic [1:0] {IDLE, DEC, FIN} state_t;
   state_t            state_q;
   logic [CHAR_W-1:0] buf_q [SEARCH_DEPTH];
   logic [POS_W-1:0]  pos_q;
   logic [LEN_W-1:0]  len_q, cnt_q;
   logic [CHAR_W-1:0] lit_q, char_q;
   logic              out_valid_q, finish_q, pos_err_q;
   logic              adv, accept, last, pos_bad;
   logic [CHAR_W-1:0] copy_d, emit_d;

   // An out-of-range position matches no entry, so the copy naturally reads as zero.
   always_comb begin
      copy_d = '0;
      for (int i = 0; i < SEARCH_DEPTH; i++)
         if (pos_q == POS_W'(i)) copy_d = buf_q[i];
   end

   assign pos_bad   = {1'b0, pos_q} >= (POS_W+1)'(SEARCH_DEPTH);
   assign adv       = !out_valid_q || out_ready;
   assign last      = cnt_q == len_q;
   assign emit_d    = last ? lit_q : copy_d;
   assign in_ready  = reset && adv &&
                      (state_q == IDLE || (state_q == DEC && last && lit_q != END_CHAR));
   assign accept    = in_valid && in_ready;
   assign out_valid = out_valid_q;
   assign char_nxt  = char_q;
   assign finish    = finish_q;
   assign pos_err   = pos_err_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         buf_q       <= '{default: '0};
         pos_q       <= '0;
         len_q       <= '0;
         cnt_q       <= '0;
         lit_q       <= '0;
         char_q      <= '0;
         out_valid_q <= 1'b0;
         finish_q    <= 1'b0;
         pos_err_q   <= 1'b0;
      end else begin
         if (accept) begin
            pos_q <= code_pos;
            len_q <= code_len;
            lit_q <= chardata;
            cnt_q <= '0;
         end
         case (state_q)
            IDLE: begin
               if (adv) out_valid_q <= 1'b0;
               if (accept) state_q <= DEC;
            end
            DEC: if (adv) begin
               out_valid_q <= 1'b1;
               char_q      <= emit_d;
               buf_q[0]    <= emit_d;
               for (int i = SEARCH_DEPTH - 1; i > 0; i--) buf_q[i] <= buf_q[i-1];
               if (!last) begin
                  cnt_q <= cnt_q + 1'b1;
                  if (pos_bad) pos_err_q <= 1'b1;
               end else
                  state_q <= (lit_q == END_CHAR) ? FIN : accept ? DEC : IDLE;
            end
            FIN: if (out_valid_q && out_ready) begin
               out_valid_q <= 1'b0;
               finish_q    <= 1'b1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_lz77_decoder_stream.sv
// tb_lz77_decoder_stream: directed tokens with a scoreboard queue drained by an output monitor.
module tb_lz77_decoder_stream;
   logic       clk, reset, in_valid, in_ready, out_valid, out_ready, finish, pos_err;
   logic [3:0] code_pos;
   logic [2:0] code_len;
   logic [7:0] chardata, char_nxt;
   logic [7:0] q[$];
   int         tests = 0, fails = 0, w;
   logic       prev_stall = 0;
   logic [7:0] prev_char = 0;

   lz77_decoder_stream dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .code_pos(code_pos), .code_len(code_len), .chardata(chardata),
      .out_valid(out_valid), .out_ready(out_ready), .char_nxt(char_nxt),
      .finish(finish), .pos_err(pos_err)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_n(input logic [7:0] c, input int n);
      for (int i = 0; i < n; i++) q.push_back(c);
   endtask

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic send(input logic [3:0] p, input logic [2:0] l, input logic [7:0] c, output int waits);
      logic ok;
      in_valid = 1; code_pos = p; code_len = l; chardata = c;
      waits = 0; ok = 0;
      while (!ok && waits <= 100) begin
         @(negedge clk);
         if (in_ready) ok = 1; else waits++;
      end
      if (!ok) begin
         tests++; fails++;
         $display("FAIL send_timeout: token %0h/%0h/%0h not accepted", p, l, c);
      end
      @(posedge clk); #1;
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 200 && q.size() != 0; i++) begin
         @(posedge clk); #1;
      end
      check(name, q.size(), 0);
   endtask

   task automatic do_reset;
      #2 reset = 0;
      q.delete();
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_finish", finish, 0);
      check("rst_pos_err", pos_err, 0);
      check("rst_in_ready", in_ready, 0);
      @(negedge clk) reset = 1;
      @(posedge clk); #1;
   endtask

   initial forever begin
      @(negedge clk);
      if (reset) begin
         if (prev_stall) begin
            check("hold_valid", out_valid, 1);
            check("hold_char", char_nxt, prev_char);
         end
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               tests++; fails++;
               $display("FAIL unexpected_out: got %0h expected none", char_nxt);
            end else check("char", char_nxt, q.pop_front());
         end
         prev_stall = out_valid && !out_ready;
         prev_char  = char_nxt;
      end else prev_stall = 0;
   end

   initial begin
      reset = 1; in_valid = 0; out_ready = 1; code_pos = 0; code_len = 0; chardata = 0;
      #1 reset = 0;
      #2;
      check("init_in_ready", in_ready, 0);
      check("init_out_valid", out_valid, 0);
      check("init_char", char_nxt, 0);
      check("init_finish", finish, 0);
      check("init_pos_err", pos_err, 0);
      @(negedge clk) reset = 1;
      @(posedge clk); #1;

      push_n("a", 1);           send(0, 0, "a", w);
      push_n("a", 3); push_n("b", 1); send(0, 3, "b", w); check("b2b_wait0", w, 0);
      push_n("a", 1); push_n("b", 1); push_n("$", 1); send(1, 2, "$", w); check("b2b_wait3", w, 3);
      in_valid = 0;
      drain("drain_a");
      check("finish_set", finish, 1);
      check("fin_out_valid", out_valid, 0);
      check("fin_in_ready", in_ready, 0);
      in_valid = 1; code_pos = 0; code_len = 0; chardata = "k";
      repeat (5) @(posedge clk);
      #1 check("fin_ignore", in_ready, 0);
      check("finish_sticky", finish, 1);
      in_valid = 0;

      do_reset();
      push_n("x", 1);           send(0, 0, "x", w);
      push_n("x", 7); push_n("y", 1); send(0, 7, "y", w); check("ovl_wait0", w, 0);
      in_valid = 0;
      drain("drain_ovl");
      check("ovl_pos_err", pos_err, 0);

      push_n("a", 1);           send(0, 0, "a", w);
      push_n("a", 3); push_n("b", 1); send(0, 3, "b", w);
      in_valid = 0;
      @(posedge clk); #1 out_ready = 0;
      repeat (3) @(posedge clk);
      #1 out_ready = 1;
      drain("drain_bp");

      push_n(8'h00, 2); push_n("c", 1); send(12, 2, "c", w);
      push_n("c", 1); push_n("d", 1); send(0, 1, "d", w);
      in_valid = 0;
      drain("drain_bad");
      check("pos_err_set", pos_err, 1);
      push_n("e", 1);           send(0, 0, "e", w);
      in_valid = 0;
      drain("drain_e");
      check("pos_err_sticky", pos_err, 1);

      push_n("e", 5); push_n("z", 1); send(0, 5, "z", w);
      in_valid = 0;
      @(posedge clk); #1;
      check("mid_valid", out_valid, 1);
      do_reset();
      push_n(8'h00, 1); push_n("q", 1); send(2, 1, "q", w);
      in_valid = 0;
      drain("drain_q");
      repeat (3) @(posedge clk);
      #1 check("sb_empty", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/lz77_decoder_stream.md
Name: lz77_decoder_stream

Overview:
- Parametrised streaming LZ77 decoder for the codec datapath.
- Accepts (code_pos, code_len, chardata) tokens over a valid/ready handshake and expands each into code_len copied characters plus one literal. Emits one character per cycle over a valid/ready output.
- Search-buffer depth, character width and field widths are parameters. Adds input and output back-pressure, an out-of-range position flag and a sticky finish.

Parameters:
SEARCH_DEPTH, 9, number of characters in the search buffer (≥2)
CHAR_W, 8, bits per character
POS_W, 4, width of code_pos; must satisfy 2^POS_W ≥ SEARCH_DEPTH
LEN_W, 3, width of code_len; max copy length 2^LEN_W−1
END_CHAR, 8'h24, terminating literal ('$'), CHAR_W bits

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
in_valid  in  1  token present on code_pos/code_len/chardata
in_ready  out  1  decoder can accept a token this cycle
code_pos  in  POS_W  copy offset into search buffer, 0 = most recent char
code_len  in  LEN_W  number of characters to copy before the literal
chardata  in  CHAR_W  literal appended after the copy
out_valid  out  1  char_nxt holds a decoded character
out_ready  in  1  consumer accepts char_nxt this cycle
char_nxt  out  CHAR_W  decoded character (registered)
finish  out  1  END_CHAR literal has been delivered; sticky
pos_err  out  1  sticky: a copy used code_pos ≥ SEARCH_DEPTH

Behaviour:
- Reset (reset=0, async): state IDLE; search buffer all zero; count 0; in_ready=0 while in reset; out_valid=0, char_nxt=0, finish=0, pos_err=0.
- Search buffer: shift register; entry 0 is the newest emitted char. Each emitted char shifts in at entry 0 and drops entry SEARCH_DEPTH−1.
- Token register: holds pos, len, char of the active token. Accept when in_valid && in_ready; inputs sampled on that edge.
- Advance condition: adv = !out_valid || out_ready. Output register and search buffer update only on adv.
- States:
  - IDLE: in_ready=1 (unless finish). On accept, go to DEC with count=0.
  - DEC, on each adv:
    - If count < len: emit buf[pos] and count++.
    - If count == len: emit the literal. If literal == END_CHAR go to FIN; else in_ready is asserted combinationally this cycle, so a new token is accepted with no bubble (stay DEC, count=0). If no token arrives, go to IDLE.
  - FIN: in_ready=0. Once the END_CHAR output is accepted (out_valid && out_ready), finish=1 and out_valid=0. Stays in FIN until reset; further tokens are ignored.
- Copy uses the current buffer contents, which already include chars emitted by this token. Overlapping copies (len > pos+1) therefore replicate runs correctly.
- Latency:
  - Accept at edge T → first char valid after edge T+1.
  - A token produces exactly len+1 outputs.
  - Sustained throughput is 1 char/cycle with out_ready=1.
- Stall: while out_valid && !out_ready, char_nxt, buffer, count and state are frozen and in_ready=0.
- Out-of-range position: code_pos ≥ SEARCH_DEPTH with len>0 emits 0 for each copy and sets pos_err. Decoding continues. len=0 never checks pos.
- out_valid drops only when a char is accepted and no new char is produced the same edge (IDLE with no token).
- Reset mid-token: discards the token and clears the buffer; the next token decodes against a zero buffer.

Test Plan:
- After reset, tokens (0,0,'a'), (0,3,'b'), out_ready=1, back-to-back → char_nxt 'a','a','a','a','b' on 5 consecutive cycles; in_ready never low between tokens.
- Continue with (1,2,'$') → outputs 'a','b','$'; finish=1 the cycle after '$' is accepted; in_ready=0 thereafter; an extra token is ignored.
- Overlap: (0,0,'x'), (0,7,'y') → eight 'x' then 'y'; pos_err stays 0.
- Back-pressure: during the (0,3,'b') expansion, drop out_ready for 3 cycles → char_nxt held stable; sequence unchanged; no chars lost or duplicated.
- Bad position, SEARCH_DEPTH=9: token (12,2,'c') → outputs 0,0,'c'; pos_err=1 and sticky; following token (0,1,'d') → 'c','d'.
- Async reset: assert reset low mid-way through (0,5,'z') between clock edges → out_valid, finish, pos_err go to 0 immediately. Next token (2,1,'q') → 0,'q'.
